// File: rtl/vproc_div_op_issue_if.sv
// Request and DIV pipe_in bundle for the DIV issue stage.
// master = issue stage view, slave = decode / DIV unit view.
interface vproc_div_op_issue_if #(
  parameter int unsigned VREG_W   = 128,
  parameter int unsigned DIV_OP_W = 64
);
  localparam int unsigned CB    = DIV_OP_W / 8;
  localparam int unsigned VL_W  = $clog2(VREG_W / 8) + 1;
  localparam int unsigned VLP_W = $clog2(CB);

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [VREG_W-1:0]     req_op1_i;
  logic [VREG_W-1:0]     req_op2_i;
  logic [VREG_W/8-1:0]   req_mask_i;
  logic [VL_W-1:0]       req_vl_i;
  logic [1:0]            req_eew_i;
  logic                  req_rem_i;
  logic                  req_signed_i;
  logic                  req_masked_i;

  logic                  pipe_valid_o;
  logic                  pipe_ready_i;
  logic [DIV_OP_W-1:0]   pipe_op1_o;
  logic [DIV_OP_W-1:0]   pipe_op2_o;
  logic [CB-1:0]         pipe_mask_o;
  logic [1:0]            pipe_eew_o;
  logic                  pipe_rem_o;
  logic                  pipe_signed_o;
  logic                  pipe_masked_o;
  logic [VLP_W-1:0]      pipe_vl_part_o;
  logic                  pipe_vl_part_0_o;
  logic                  pipe_first_o;
  logic                  pipe_last_o;

  modport master (
    input  req_valid_i, req_op1_i, req_op2_i, req_mask_i, req_vl_i,
           req_eew_i, req_rem_i, req_signed_i, req_masked_i, pipe_ready_i,
    output req_ready_o, pipe_valid_o, pipe_op1_o, pipe_op2_o, pipe_mask_o,
           pipe_eew_o, pipe_rem_o, pipe_signed_o, pipe_masked_o,
           pipe_vl_part_o, pipe_vl_part_0_o, pipe_first_o, pipe_last_o
  );

  modport slave (
    output req_valid_i, req_op1_i, req_op2_i, req_mask_i, req_vl_i,
           req_eew_i, req_rem_i, req_signed_i, req_masked_i, pipe_ready_i,
    input  req_ready_o, pipe_valid_o, pipe_op1_o, pipe_op2_o, pipe_mask_o,
           pipe_eew_o, pipe_rem_o, pipe_signed_o, pipe_masked_o,
           pipe_vl_part_o, pipe_vl_part_0_o, pipe_first_o, pipe_last_o
  );
endinterface

// File: rtl/vproc_div_op_issue.sv
// DIV issue stage: slices one vector-register-wide divide request into
// DIV_OP_W chunks with per-chunk tail information for the DIV unit.

module vproc_div_op_issue_chk #(
  parameter int unsigned VREG_W = 128,
  parameter int unsigned VL_W   = 5
) (
  input logic            i_clk,
  input logic            i_rst_n,
  input logic            i_valid,
  input logic            i_ready,
  input logic [VL_W-1:0] i_vl,
  input logic [1:0]      i_eew
);
  function automatic logic vl_legal(input logic [VL_W-1:0] vl, input logic [1:0] eew);
    logic [VL_W-1:0] align;
    logic            eew_ok;
    case (eew)
      2'd0:    begin align = VL_W'(0); eew_ok = 1'b1; end
      2'd1:    begin align = VL_W'(1); eew_ok = 1'b1; end
      2'd2:    begin align = VL_W'(3); eew_ok = 1'b1; end
      default: begin align = VL_W'(3); eew_ok = 1'b0; end
    endcase
    return eew_ok && (vl <= VL_W'(VREG_W / 8)) && ((vl & align) == VL_W'(0));
  endfunction

  a_vl_legal: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                               (i_valid && i_ready) |-> vl_legal(i_vl, i_eew))
    else $error("vproc_div_op_issue: illegal vl %0d for eew %0d", i_vl, i_eew);
endmodule

module vproc_div_op_issue #(
  parameter int unsigned VREG_W    = 128,
  parameter int unsigned DIV_OP_W  = 64,
  parameter bit          SKIP_TAIL = 1'b1
) (
  input logic                  clk_i,
  input logic                  async_rst_ni,
  vproc_div_op_issue_if.master io_if
);
  localparam int unsigned CB     = DIV_OP_W / 8;
  localparam int unsigned NCH    = VREG_W / DIV_OP_W;
  localparam int unsigned VL_W   = $clog2(VREG_W / 8) + 1;
  localparam int unsigned VLP_W  = $clog2(CB);
  localparam int unsigned K_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NCH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [VREG_W-1:0]   r_op1;
  logic [VREG_W-1:0]   r_op2;
  logic [VREG_W/8-1:0] r_mask;
  logic [VL_W-1:0]     r_vl;
  logic [1:0]          r_eew;
  logic                r_rem;
  logic                r_signed;
  logic                r_masked;
  logic [K_W-1:0]      r_k;

  logic                w_load;
  logic                w_k_inc;
  logic                w_req_ready;
  logic                w_last;
  logic [VL_W-1:0]     w_base;
  logic [VL_W:0]       w_end;
  logic [VL_W-1:0]     w_rem;
  logic [VLP_W-1:0]    w_vl_part;
  logic                w_vl_part_0;

  logic [DIV_OP_W-1:0] w_op1_ch  [NCH];
  logic [DIV_OP_W-1:0] w_op2_ch  [NCH];
  logic [CB-1:0]       w_mask_ch [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    assign w_op1_ch[g]  = r_op1[g*DIV_OP_W +: DIV_OP_W];
    assign w_op2_ch[g]  = r_op2[g*DIV_OP_W +: DIV_OP_W];
    assign w_mask_ch[g] = r_mask[g*CB +: CB];
  end

  assign w_base = VL_W'(r_k * CB);
  assign w_end  = {1'b0, w_base} + (VL_W+1)'(CB);
  assign w_rem  = r_vl - w_base;

  // Tail info: vl - k*CB <= 0 is the same as vl <= k*CB, which avoids signed math
  always_comb begin
    w_vl_part   = VLP_W'(0);
    w_vl_part_0 = 1'b0;
    if (r_vl <= w_base) begin
      w_vl_part_0 = 1'b1;
      w_vl_part   = VLP_W'(0);
    end else if (w_rem >= VL_W'(CB)) begin
      w_vl_part_0 = 1'b0;
      w_vl_part   = VLP_W'(CB - 1);
    end else begin
      w_vl_part_0 = 1'b0;
      w_vl_part   = VLP_W'(w_rem - VL_W'(1));
    end
  end

  // Last-chunk detection; with tail skipping the request ends at the chunk covering vl
  always_comb begin
    w_last = 1'b0;
    if (r_k == K_LAST) begin
      w_last = 1'b1;
    end else if (SKIP_TAIL && (w_end >= {1'b0, r_vl})) begin
      w_last = 1'b1;
    end else begin
      w_last = 1'b0;
    end
  end

  // Next-state and handshake control
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_k_inc     = 1'b0;
    w_req_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = 1'b1;
        if (io_if.req_valid_i) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (io_if.pipe_ready_i) begin
          if (w_last) begin
            // Accepting here lets a follow-up request issue with no bubble
            w_req_ready = 1'b1;
            if (io_if.req_valid_i) begin
              w_load      = 1'b1;
              w_state_nxt = ST_ISSUE;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_k_inc = 1'b1;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request capture
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_op1    <= '0;
      r_op2    <= '0;
      r_mask   <= '0;
      r_vl     <= '0;
      r_eew    <= 2'd0;
      r_rem    <= 1'b0;
      r_signed <= 1'b0;
      r_masked <= 1'b0;
    end else if (w_load) begin
      r_op1    <= io_if.req_op1_i;
      r_op2    <= io_if.req_op2_i;
      r_mask   <= io_if.req_mask_i;
      r_vl     <= io_if.req_vl_i;
      r_eew    <= io_if.req_eew_i;
      r_rem    <= io_if.req_rem_i;
      r_signed <= io_if.req_signed_i;
      r_masked <= io_if.req_masked_i;
    end
  end

  // Chunk counter
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_k <= K_W'(0);
    end else if (w_load) begin
      r_k <= K_W'(0);
    end else if (w_k_inc) begin
      r_k <= r_k + K_W'(1);
    end
  end

  assign io_if.req_ready_o      = w_req_ready;
  assign io_if.pipe_valid_o     = (r_state == ST_ISSUE);
  assign io_if.pipe_op1_o       = w_op1_ch[r_k];
  assign io_if.pipe_op2_o       = w_op2_ch[r_k];
  assign io_if.pipe_mask_o      = w_mask_ch[r_k];
  assign io_if.pipe_eew_o       = r_eew;
  assign io_if.pipe_rem_o       = r_rem;
  assign io_if.pipe_signed_o    = r_signed;
  assign io_if.pipe_masked_o    = r_masked;
  assign io_if.pipe_vl_part_o   = w_vl_part;
  assign io_if.pipe_vl_part_0_o = w_vl_part_0;
  assign io_if.pipe_first_o     = (r_k == K_W'(0));
  assign io_if.pipe_last_o      = w_last;

  vproc_div_op_issue_chk #(
    .VREG_W (VREG_W),
    .VL_W   (VL_W)
  ) u_chk (
    .i_clk   (clk_i),
    .i_rst_n (async_rst_ni),
    .i_valid (io_if.req_valid_i),
    .i_ready (w_req_ready),
    .i_vl    (io_if.req_vl_i),
    .i_eew   (io_if.req_eew_i)
  );
endmodule
